// File: rtl/trakball_pkg.sv
// Shared constants and types for the trackball step/direction receiver.
package trakball_pkg;

    // Axis numbering used for per-axis arrays and the moved_o bit order.
    localparam int AXIS_X = 1;
    localparam int AXIS_Y = 0;

    // Bit positions inside trak_i = {x_dir, x_step, y_dir, y_step}.
    localparam int TRAK_IDX_Y_STEP = 0;
    localparam int TRAK_IDX_Y_DIR  = 1;
    localparam int TRAK_IDX_X_STEP = 2;
    localparam int TRAK_IDX_X_DIR  = 3;

    // Default position counter width and its matching type.
    localparam int TRAK_CNT_W = 4;
    typedef logic [TRAK_CNT_W-1:0] trak_cnt_t;

endpackage

// File: rtl/trak_line_filter.sv
// One input line: synchronizer chain followed by a stability filter.
// The accepted level only moves after the synchronized line has shown the
// same level for FILT_LEN consecutive cycles, so shorter glitches vanish.
module trak_line_filter #(
    parameter int SYNC_LEN = 2,
    parameter int FILT_LEN = 3
) (
    input  logic clk_sys,
    input  logic reset_n,
    input  logic din,
    output logic level
);

    localparam int RUN_W = $clog2(FILT_LEN + 1);

    logic [SYNC_LEN-1:0] sync_chain;
    logic                synced;
    logic                cand;
    logic [RUN_W-1:0]    run_cnt;
    logic [RUN_W-1:0]    run_next;

    assign synced = sync_chain[SYNC_LEN-1];

    // Metastability chain: shift the raw line in from the bottom.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            sync_chain <= '0;
        end else begin
            sync_chain <= {sync_chain[SYNC_LEN-2:0], din};
        end
    end

    // Length of the current run of equal synced samples, saturating at FILT_LEN.
    always_comb begin
        run_next = run_cnt;
        if (synced != cand) begin
            run_next = RUN_W'(1);
        end else if (run_cnt != RUN_W'(FILT_LEN)) begin
            run_next = run_cnt + RUN_W'(1);
        end
    end

    // Track the candidate level and accept it once its run is long enough.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            cand    <= 1'b0;
            run_cnt <= '0;
            level   <= 1'b0;
        end else begin
            cand    <= synced;
            run_cnt <= run_next;
            if (run_next == RUN_W'(FILT_LEN)) begin
                level <= synced;
            end
        end
    end

endmodule

// File: rtl/trakball_quad_decoder.sv
// Trackball step/direction receiver: filters the four lines, turns each
// accepted step toggle into one count on a wrapping up/down counter per
// axis, and hands the CPU a coherent X/Y snapshot on each read strobe.
module trakball_quad_decoder
    import trakball_pkg::*;
#(
    parameter int CNT_W    = TRAK_CNT_W,
    parameter int SYNC_LEN = 2,
    parameter int FILT_LEN = 3
) (
    input  logic             clk_sys,
    input  logic             reset_n,
    input  logic [3:0]       trak_i,
    input  logic             flip_i,
    input  logic             clr_i,
    input  logic             rd_i,
    output logic [CNT_W-1:0] x_cnt_o,
    output logic [CNT_W-1:0] y_cnt_o,
    output logic [1:0]       moved_o
);

    // Wrapping one-step move of a position count.
    function automatic logic [CNT_W-1:0] step_count(
        input logic [CNT_W-1:0] value,
        input logic             count_up
    );
        return count_up ? (value + CNT_W'(1)) : (value - CNT_W'(1));
    endfunction

    logic [3:0]       trak_acc;
    logic [CNT_W-1:0] snap_arr [2];

    // ---- Input conditioning: one filter per line ----
    for (genvar l = 0; l < 4; l++) begin : g_line
        trak_line_filter #(
            .SYNC_LEN (SYNC_LEN),
            .FILT_LEN (FILT_LEN)
        ) u_filter (
            .clk_sys (clk_sys),
            .reset_n (reset_n),
            .din     (trak_i[l]),
            .level   (trak_acc[l])
        );
    end

    // ---- Per-axis step detect, counter, snapshot and moved flag ----
    for (genvar a = 0; a < 2; a++) begin : g_axis
        localparam int STEP_IDX = (a == AXIS_X) ? TRAK_IDX_X_STEP : TRAK_IDX_Y_STEP;
        localparam int DIR_IDX  = (a == AXIS_X) ? TRAK_IDX_X_DIR  : TRAK_IDX_Y_DIR;

        logic             step_d1;
        logic             step_ev;
        logic             count_up;
        logic [CNT_W-1:0] live;
        logic [CNT_W-1:0] snap;
        logic             moved;

        // Any toggle of the accepted step level is exactly one count.
        assign step_ev  = trak_acc[STEP_IDX] ^ step_d1;
        assign count_up = trak_acc[DIR_IDX] ^ flip_i;

        // Delayed accepted step level; resets to 0 so a line idling high
        // after reset produces one count, like the original counter chips.
        always_ff @(posedge clk_sys or negedge reset_n) begin
            if (!reset_n) begin
                step_d1 <= 1'b0;
            end else begin
                step_d1 <= trak_acc[STEP_IDX];
            end
        end

        // Live count, CPU snapshot and sticky moved flag; clear wins over all.
        always_ff @(posedge clk_sys or negedge reset_n) begin
            if (!reset_n) begin
                live  <= '0;
                snap  <= '0;
                moved <= 1'b0;
            end else if (clr_i) begin
                live  <= '0;
                snap  <= '0;
                moved <= 1'b0;
            end else begin
                // Snapshot takes the pre-step value when a read meets a step.
                if (rd_i) begin
                    snap <= live;
                end
                if (step_ev) begin
                    live  <= step_count(live, count_up);
                    moved <= 1'b1;
                end else if (rd_i) begin
                    moved <= 1'b0;
                end
            end
        end

        assign snap_arr[a] = snap;
        assign moved_o[a]  = moved;
    end

    assign x_cnt_o = snap_arr[AXIS_X];
    assign y_cnt_o = snap_arr[AXIS_Y];

endmodule

// File: tb/tb_trakball_quad_decoder.sv
// Bench for trakball_quad_decoder: a queue-based model of the receive path
// checked every cycle, plus directed scenarios with literal expectations.
module tb_trakball_quad_decoder;
    import trakball_pkg::*;

    localparam int CNT_W    = 4;
    localparam int SYNC_LEN = 2;
    localparam int FILT_LEN = 3;
    localparam int MODV     = 1 << CNT_W;

    logic             clk_sys = 1'b0;
    logic             reset_n = 1'b0;
    logic [3:0]       trak_i  = 4'hF;
    logic             flip_i  = 1'b0;
    logic             clr_i   = 1'b0;
    logic             rd_i    = 1'b0;
    logic [CNT_W-1:0] x_cnt_o;
    logic [CNT_W-1:0] y_cnt_o;
    logic [1:0]       moved_o;

    int n_checks = 0;
    int n_fail   = 0;

    trakball_quad_decoder #(
        .CNT_W    (CNT_W),
        .SYNC_LEN (SYNC_LEN),
        .FILT_LEN (FILT_LEN)
    ) dut (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .trak_i  (trak_i),
        .flip_i  (flip_i),
        .clr_i   (clr_i),
        .rd_i    (rd_i),
        .x_cnt_o (x_cnt_o),
        .y_cnt_o (y_cnt_o),
        .moved_o (moved_o)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Each line: raw value delayed SYNC_LEN edges, then accepted once the
    // last FILT_LEN delayed samples all agree.
    bit dq  [4][$];
    bit win [4][$];
    bit m_acc [4];
    bit m_step_prev [2];
    int m_live [2];
    int m_snap [2];
    bit m_moved [2];

    always @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            for (int l = 0; l < 4; l++) begin
                dq[l].delete();
                win[l].delete();
                for (int k = 0; k < SYNC_LEN; k++) dq[l].push_back(1'b0);
                m_acc[l] = 1'b0;
            end
            for (int a = 0; a < 2; a++) begin
                m_step_prev[a] = 1'b0;
                m_live[a]      = 0;
                m_snap[a]      = 0;
                m_moved[a]     = 1'b0;
            end
        end else begin
            for (int a = 0; a < 2; a++) begin
                int  si;
                int  di;
                bit  ev;
                bit  up;
                si = (a == AXIS_X) ? TRAK_IDX_X_STEP : TRAK_IDX_Y_STEP;
                di = (a == AXIS_X) ? TRAK_IDX_X_DIR  : TRAK_IDX_Y_DIR;
                ev = (m_acc[si] != m_step_prev[a]);
                up = m_acc[di] ^ flip_i;
                if (clr_i) begin
                    m_live[a]  = 0;
                    m_snap[a]  = 0;
                    m_moved[a] = 1'b0;
                end else begin
                    if (rd_i) m_snap[a] = m_live[a];
                    if (ev) begin
                        m_live[a]  = (m_live[a] + (up ? 1 : MODV - 1)) % MODV;
                        m_moved[a] = 1'b1;
                    end else if (rd_i) begin
                        m_moved[a] = 1'b0;
                    end
                end
                m_step_prev[a] = m_acc[si];
            end
            for (int l = 0; l < 4; l++) begin
                bit s;
                bit same;
                dq[l].push_back(trak_i[l]);
                s = dq[l].pop_front();
                win[l].push_back(s);
                if (win[l].size() > FILT_LEN) void'(win[l].pop_front());
                same = 1'b1;
                foreach (win[l][i]) if (win[l][i] != s) same = 1'b0;
                if (win[l].size() == FILT_LEN && same) m_acc[l] = s;
            end
        end
    end

    // Every cycle, away from the active edge, compare DUT against the model.
    always @(negedge clk_sys) begin
        check("model_x_cnt", int'(x_cnt_o), m_snap[AXIS_X]);
        check("model_y_cnt", int'(y_cnt_o), m_snap[AXIS_Y]);
        check("model_moved", int'(moved_o), int'({m_moved[AXIS_X], m_moved[AXIS_Y]}));
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    task automatic rd_pulse();
        rd_i = 1'b1;
        tick(1);
        rd_i = 1'b0;
    endtask

    task automatic clr_pulse();
        clr_i = 1'b1;
        tick(1);
        clr_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed scenarios ----------------
    initial begin
        // Reset held with all lines high.
        tick(3);
        check("reset_x", int'(x_cnt_o), 0);
        check("reset_y", int'(y_cnt_o), 0);
        check("reset_moved", int'(moved_o), 0);

        // Release with lines still high: one count per axis.
        reset_n = 1'b1;
        tick(10);
        check("release_moved", int'(moved_o), 3);
        rd_pulse();
        check("release_x", int'(x_cnt_o), 1);
        check("release_y", int'(y_cnt_o), 1);
        check("release_moved_cleared", int'(moved_o), 0);

        // Up count with latency check on moved_o[X].
        clr_pulse();
        check("clr_x", int'(x_cnt_o), 0);
        for (int t = 0; t < 5; t++) begin
            trak_i[TRAK_IDX_X_STEP] = ~trak_i[TRAK_IDX_X_STEP];
            for (int c = 1; c <= 6; c++) begin
                tick(1);
                check("latency_moved_x", int'(moved_o[AXIS_X]), (c == 6) ? 1 : 0);
            end
            rd_pulse();
            tick(13);
        end
        rd_pulse();
        check("upcount_x", int'(x_cnt_o), 5);

        // Wrap down from 0, then back up through 0.
        clr_pulse();
        trak_i[TRAK_IDX_X_DIR] = 1'b0;
        tick(10);
        trak_i[TRAK_IDX_X_STEP] = ~trak_i[TRAK_IDX_X_STEP];
        tick(10);
        rd_pulse();
        check("wrap_down_x", int'(x_cnt_o), 15);
        trak_i[TRAK_IDX_X_DIR] = 1'b1;
        tick(10);
        for (int t = 0; t < 2; t++) begin
            trak_i[TRAK_IDX_X_STEP] = ~trak_i[TRAK_IDX_X_STEP];
            tick(10);
        end
        rd_pulse();
        check("wrap_up_x", int'(x_cnt_o), 1);

        // Two-cycle glitch is discarded; a held change counts once.
        trak_i[TRAK_IDX_X_STEP] = ~trak_i[TRAK_IDX_X_STEP];
        tick(2);
        trak_i[TRAK_IDX_X_STEP] = ~trak_i[TRAK_IDX_X_STEP];
        tick(12);
        check("glitch_moved_x", int'(moved_o[AXIS_X]), 0);
        rd_pulse();
        check("glitch_x", int'(x_cnt_o), 1);
        trak_i[TRAK_IDX_X_STEP] = ~trak_i[TRAK_IDX_X_STEP];
        tick(12);
        check("stable_moved_x", int'(moved_o[AXIS_X]), 1);
        rd_pulse();
        check("stable_x", int'(x_cnt_o), 2);

        // Flip inverts direction on both axes.
        clr_pulse();
        flip_i = 1'b1;
        trak_i[TRAK_IDX_Y_DIR] = 1'b0;
        tick(10);
        for (int t = 0; t < 3; t++) begin
            trak_i[TRAK_IDX_X_STEP] = ~trak_i[TRAK_IDX_X_STEP];
            trak_i[TRAK_IDX_Y_STEP] = ~trak_i[TRAK_IDX_Y_STEP];
            tick(10);
        end
        rd_pulse();
        check("flip_x", int'(x_cnt_o), 13);
        check("flip_y", int'(y_cnt_o), 3);

        // Read coinciding with a step event: snapshot holds the old value.
        trak_i[TRAK_IDX_X_STEP] = ~trak_i[TRAK_IDX_X_STEP];
        tick(5);
        rd_i = 1'b1;
        tick(1);
        rd_i = 1'b0;
        check("rd_step_x_old", int'(x_cnt_o), 13);
        check("rd_step_moved_x", int'(moved_o[AXIS_X]), 1);
        tick(2);
        rd_pulse();
        check("rd_step_x_new", int'(x_cnt_o), 12);

        // Clear and read together during a step event.
        trak_i[TRAK_IDX_X_STEP] = ~trak_i[TRAK_IDX_X_STEP];
        tick(5);
        clr_i = 1'b1;
        rd_i  = 1'b1;
        tick(1);
        clr_i = 1'b0;
        rd_i  = 1'b0;
        check("clr_rd_x", int'(x_cnt_o), 0);
        check("clr_rd_y", int'(y_cnt_o), 0);
        check("clr_rd_moved", int'(moved_o), 0);
        tick(10);
        rd_pulse();
        check("clr_rd_live_x", int'(x_cnt_o), 0);

        // Reset mid-stream: x_step idles high, y_step idles low.
        flip_i  = 1'b0;
        reset_n = 1'b0;
        tick(2);
        check("midreset_x", int'(x_cnt_o), 0);
        check("midreset_moved", int'(moved_o), 0);
        reset_n = 1'b1;
        tick(12);
        check("midrelease_moved", int'(moved_o), 2);
        rd_pulse();
        check("midrelease_x", int'(x_cnt_o), 1);
        check("midrelease_y", int'(y_cnt_o), 0);

        tick(3);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
